// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD16  = 2'b00,
    SUB16  = 2'b01,
    PADDSB = 2'b10,
    PSUBSB = 2'b11
  } alu_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } alu_state_e;

  localparam logic [3:0] SAT_POS = 4'h7;
  localparam logic [3:0] SAT_NEG = 4'h8;

  // Bit positions inside flags = {Z, V, N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/addsub_nibble.sv
// 4-bit add/subtract slice with explicit carry-in so carries can chain across cycles.
module addsub_nibble (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       sub,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       Ovfl
);

  logic [3:0] b_x;
  logic [4:0] c;

  assign b_x  = B ^ {4{sub}};
  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder_1bit u_fa (
      .a    (A[i]),
      .b    (b_x[i]),
      .cin  (c[i]),
      .sum  (Sum[i]),
      .cout (c[i+1])
    );
  end

  assign Cout = c[4];
  // Signed overflow: carry into the MSB differs from carry out of it
  assign Ovfl = c[3] ^ c[4];

endmodule

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequences one 4-bit add/sub slice over four cycles (LS nibble first) for
// 16-bit add/sub or packed 4x4-bit saturating add/sub.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing nibble idx (0..3), busy=1
// DONE  | one-cycle done pulse, result/flags valid; start here chains the next op
module nibble_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [2:0]  flags
);

  alu_state_e  state_q, state_d;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic        ovf_any_q;
  logic [15:0] a_q, b_q;
  logic [1:0]  mode_q;
  logic [15:0] acc_q;
  logic [15:0] result_q;
  logic [2:0]  flags_q;

  logic        accept;
  logic        last_nib;
  logic        packed_mode;
  logic [3:0]  a_nib, b_nib;
  logic        slice_cin;
  logic [3:0]  slice_sum;
  logic        slice_cout;
  logic        slice_ovfl;
  logic [3:0]  nib_val;
  logic [15:0] res_final;

  assign accept      = start && (state_q == IDLE || state_q == DONE);
  assign last_nib    = (idx_q == 2'(NIBBLES - 1));
  assign packed_mode = mode_q[1];
  assign a_nib       = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib       = b_q[{idx_q, 2'b00} +: 4];
  // Packed lanes are independent: each nibble starts with its own carry-in
  assign slice_cin   = packed_mode ? mode_q[0] : carry_q;

  addsub_nibble u_slice (
    .A    (a_nib),
    .B    (b_nib),
    .sub  (mode_q[0]),
    .Cin  (slice_cin),
    .Sum  (slice_sum),
    .Cout (slice_cout),
    .Ovfl (slice_ovfl)
  );

  always_comb begin
    nib_val = slice_sum;
    if (packed_mode && slice_ovfl) begin
      nib_val = a_nib[3] ? SAT_NEG : SAT_POS;
    end
  end

  assign res_final = {nib_val, acc_q[11:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign result = result_q;
  assign flags  = flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      carry_q   <= 1'b0;
      ovf_any_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      mode_q    <= mode;
      idx_q     <= '0;
      carry_q   <= mode[0];
      ovf_any_q <= 1'b0;
    end else if (state_q == RUN) begin
      acc_q[{idx_q, 2'b00} +: 4] <= nib_val;
      carry_q   <= slice_cout;
      ovf_any_q <= ovf_any_q | (packed_mode & slice_ovfl);
      idx_q     <= idx_q + 2'd1;
      if (last_nib) begin
        result_q        <= res_final;
        flags_q[FLAG_Z] <= (res_final == 16'h0000);
        flags_q[FLAG_N] <= res_final[15];
        flags_q[FLAG_V] <= packed_mode ? (ovf_any_q | slice_ovfl) : slice_ovfl;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: directed vectors plus random ops against an arithmetic reference model.
module tb_nibble_serial_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_result;
  logic [2:0]  prev_flags;

  always #5 clk = ~clk;

  nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Returns {Z, V, N, result} from plain signed arithmetic
  function automatic logic [18:0] ref_model(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y);
    int sa, sb, r;
    logic signed [3:0] nx, ny;
    logic [15:0] res;
    logic v;
    res = '0;
    v   = 1'b0;
    if (!m[1]) begin
      sa = $signed(x);
      sb = $signed(y);
      r  = m[0] ? sa - sb : sa + sb;
      res = r[15:0];
      v   = (r > 32767) || (r < -32768);
    end else begin
      for (int i = 0; i < 4; i++) begin
        nx = x[4*i +: 4];
        ny = y[4*i +: 4];
        sa = nx;
        sb = ny;
        r  = m[0] ? sa - sb : sa + sb;
        if (r > 7) begin r = 7; v = 1'b1; end
        else if (r < -8) begin r = -8; v = 1'b1; end
        res[4*i +: 4] = r[3:0];
      end
    end
    return {res == 16'h0, v, res[15], res};
  endfunction

  // Present a start at the next negedge; it is sampled at the following posedge.
  task automatic issue(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = y;
  endtask

  // Called right after start was presented; checks cycles 1..5 and ends at the DONE negedge.
  task automatic run_checks(input string tag, input logic [1:0] m, input logic [15:0] x,
                            input logic [15:0] y, input bit hold);
    logic [18:0] exp;
    exp = ref_model(m, x, y);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a = $urandom;
    b = $urandom;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_val({tag, ".busy"}, busy, 1'b1);
      check_val({tag, ".nodone"}, done, 1'b0);
      check_val({tag, ".hold_res"}, {flags, result}, {prev_flags, prev_result});
    end
    @(negedge clk);
    check_val({tag, ".done"}, done, 1'b1);
    check_val({tag, ".busy5"}, busy, 1'b0);
    check_val({tag, ".result"}, result, exp[15:0]);
    check_val({tag, ".flags"}, flags, exp[18:16]);
    prev_result = exp[15:0];
    prev_flags  = exp[18:16];
  endtask

  task automatic one_op(input string tag, input logic [1:0] m, input logic [15:0] x, input logic [15:0] y);
    issue(m, x, y);
    run_checks(tag, m, x, y, 1'b0);
  endtask

  initial begin
    logic [1:0]  rm;
    logic [15:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    a = '0;
    b = '0;
    prev_result = '0;
    prev_flags  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.busy", busy, 1'b0);
    check_val("rst.done", done, 1'b0);
    check_val("rst.result", result, 16'h0000);
    check_val("rst.flags", flags, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    one_op("add_ovf", 2'b00, 16'h7FFF, 16'h0001);
    check_val("add_ovf.lit", {flags, result}, {3'b011, 16'h8000});
    one_op("sub_borrow", 2'b01, 16'h0100, 16'h0001);
    check_val("sub_borrow.lit", {flags, result}, {3'b000, 16'h00FF});
    one_op("sub_zero", 2'b01, 16'h1234, 16'h1234);
    check_val("sub_zero.lit", {flags, result}, {3'b100, 16'h0000});
    one_op("paddsb", 2'b10, 16'h783F, 16'h1F21);
    check_val("paddsb.lit", {flags, result}, {3'b010, 16'h7850});
    one_op("psubsb_sat", 2'b11, 16'h8000, 16'h1000);
    check_val("psubsb_sat.lit", {flags, result}, {3'b011, 16'h8000});
    one_op("psubsb_zero", 2'b11, 16'h1111, 16'h1111);
    check_val("psubsb_zero.lit", {flags, result}, {3'b100, 16'h0000});

    // start held high through RUN: exactly one op, then idle
    issue(2'b00, 16'h0005, 16'h0006);
    run_checks("hold", 2'b00, 16'h0005, 16'h0006, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check_val("hold.idle_busy", busy, 1'b0);
    check_val("hold.idle_done", done, 1'b0);
    check_val("hold.res", result, 16'h000B);

    // back-to-back: new start presented in the DONE cycle
    issue(2'b00, 16'h1000, 16'h0234);
    run_checks("b2b1", 2'b00, 16'h1000, 16'h0234, 1'b0);
    start = 1'b1; mode = 2'b01; a = 16'h0010; b = 16'h0020;
    run_checks("b2b2", 2'b01, 16'h0010, 16'h0020, 1'b0);

    // reset in cycle 2 aborts the operation
    issue(2'b00, 16'h4444, 16'h1111);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev_result = '0;
    prev_flags  = '0;
    for (int c = 0; c < 6; c++) begin
      check_val("abort.busy", busy, 1'b0);
      check_val("abort.done", done, 1'b0);
      check_val("abort.res", {flags, result}, 19'h0);
      @(negedge clk);
    end
    one_op("after_rst", 2'b00, 16'h0001, 16'h0002);
    check_val("after_rst.lit", result, 16'h0003);
    start = 1'b0;

    // random ops, some chained back-to-back from DONE
    for (int n = 0; n < 60; n++) begin
      rm = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 3 == 0) begin
        start = 1'b1; mode = rm; a = ra; b = rb;
        run_checks("rand_b2b", rm, ra, rb, 1'b0);
      end else begin
        one_op("rand", rm, ra, rb);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check_val("end.idle", {busy, done}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
